// File: rtl/fp32_mul_arbiter.sv
// fp32_mul_arbiter: round-robin sharing of one fp32 multiplier among NUM_REQ
// requesters, with a MUL_LAT-deep result pipeline and one tagged response port.
// fp32_mul is the shared combinational multiplier. Zero and denormal inputs
// give a signed zero. Inf and NaN inputs give a quiet NaN with the flag low.
// Rounding is round-to-nearest-even. Overflow gives a signed inf and underflow
// gives a signed zero, and both clear the flag.

module fp32_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        valid
);

  logic               sign;
  logic [47:0]        prod;
  logic signed [10:0] exp_s;
  logic signed [10:0] exp_n;
  logic signed [10:0] exp_r;
  logic [22:0]        mant;
  logic               grd;
  logic               stk;
  logic [23:0]        rnd;

  // Round-to-nearest-even on the 23-bit fraction; bit 23 flags a carry-out
  function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
    return {1'b0, m} + 24'(g & (s | m[0]));
  endfunction

  // Multiply significands, normalise, round, then classify the exponent
  always_comb begin
    sign   = a[31] ^ b[31];
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_s  = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    exp_n  = exp_s;
    mant   = prod[45:23];
    grd    = prod[22];
    stk    = |prod[21:0];
    if (prod[47]) begin
      exp_n = exp_s + 11'sd1;
      mant  = prod[46:24];
      grd   = prod[23];
      stk   = |prod[22:0];
    end
    rnd    = round_rne(mant, grd, stk);
    exp_r  = exp_n + (rnd[23] ? 11'sd1 : 11'sd0);
    result = {sign, exp_r[7:0], rnd[22:0]};
    valid  = 1'b1;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      result = 32'h7FC0_0000;
      valid  = 1'b0;
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      result = {sign, 31'b0};
      valid  = 1'b1;
    end else if (exp_r >= 11'sd255) begin
      result = {sign, 8'hFF, 23'b0};
      valid  = 1'b0;
    end else if (exp_r <= 11'sd0) begin
      result = {sign, 31'b0};
      valid  = 1'b0;
    end
  end

endmodule

module fp32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_ok,
  input  logic                    rsp_ready,
  output logic [31:0]             issue_cnt
);

  logic              adv;
  logic              accept;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  int                arb_best;
  int                arb_dist;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [31:0]       mul_res;
  logic              mul_ok;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       issue_cnt_q, issue_cnt_d;
  logic [MUL_LAT:1]  vld_q, vld_d;
  logic [MUL_LAT:1]  ok_q, ok_d;
  logic [ID_W-1:0]   id_q  [1:MUL_LAT];
  logic [ID_W-1:0]   id_d  [1:MUL_LAT];
  logic [31:0]       res_q [1:MUL_LAT];
  logic [31:0]       res_d [1:MUL_LAT];

  // The pipeline only moves as a whole, when its tail can be emptied
  assign adv    = !vld_q[MUL_LAT] || rsp_ready;
  assign accept = gnt_found && adv && !rst;

  // Round-robin: pick the valid requester closest at-or-after rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_best  = NUM_REQ;
    arb_dist  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_dist = i - int'(rr_ptr_q);
      if (arb_dist < 0) arb_dist = arb_dist + NUM_REQ;
      if (req_valid[i] && arb_dist < arb_best) begin
        arb_best  = arb_dist;
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end

  // Steer the granted operands into the multiplier and raise its ready strobe
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        mul_a        = req_a[i*32 +: 32];
        mul_b        = req_b[i*32 +: 32];
        req_ready[i] = accept;
      end
    end
  end

  fp32_mul u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_res),
    .valid  (mul_ok)
  );

  // Next-state: shift the result pipeline on adv, bump pointer and count on accept
  always_comb begin
    vld_d       = vld_q;
    ok_d        = ok_q;
    id_d        = id_q;
    res_d       = res_q;
    rr_ptr_d    = rr_ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (adv) begin
      vld_d[1] = accept;
      ok_d[1]  = mul_ok;
      id_d[1]  = gnt_idx;
      res_d[1] = mul_res;
      for (int k = 2; k <= MUL_LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        ok_d[k]  = ok_q[k-1];
        id_d[k]  = id_q[k-1];
        res_d[k] = res_q[k-1];
      end
    end
    if (accept) begin
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  // Control state: stage valids, round-robin pointer, issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      rr_ptr_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Stage data; only the output stage is cleared so rsp_* read zero after reset
  always_ff @(posedge clk) begin
    ok_q  <= ok_d;
    id_q  <= id_d;
    res_q <= res_d;
    if (rst) begin
      ok_q[MUL_LAT]  <= 1'b0;
      id_q[MUL_LAT]  <= '0;
      res_q[MUL_LAT] <= '0;
    end
  end

  assign rsp_valid  = vld_q[MUL_LAT];
  assign rsp_ok     = ok_q[MUL_LAT];
  assign rsp_id     = id_q[MUL_LAT];
  assign rsp_result = res_q[MUL_LAT];
  assign issue_cnt  = issue_cnt_q;

endmodule
